apb_csr_regs: RTL
=================

APB_CSR_REGS -- requirements
Module: apb_csr_regs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-002 SHALL have parameter INT_WIDTH, default 8, number of interrupt sources.
REQ-003 SHALL have parameter TYPE_VALUE, default 32'h0000_A5C1, constant returned by REG_TYPE.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_strobe  input  1  qualified APB write access phase (sel & en & write & !slv_err), one cycle per transfer.
REQ-007 SHALL have port rd_strobe  input  1  qualified APB read access phase, one cycle per transfer.
REQ-008 SHALL have port w_en_all  input  3  one-hot write select {MASK, INT_CLEAR, RANDOM} from the upstream decoder.
REQ-009 SHALL have port r_en_all  input  5  one-hot read select {MASK, INT_STATUS, INT_CLEAR, RANDOM, TYPE} from the upstream decoder.
REQ-010 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port int_src  input  INT_WIDTH  level interrupt requests, synchronous to clk.
REQ-012 SHALL have port rdata  output  DATA_WIDTH  registered read data.
REQ-013 SHALL have port irq  output  1  registered interrupt, OR of masked status.

Function
REQ-014 SHALL commit a write only on cycles where wr_strobe=1; bit i of w_en_all selects the target; w_en_all ignored otherwise.
REQ-015 RANDOM SHALL be a 32-bit Galois LFSR, taps 32'h8020_0003 (x^32+x^22+x^2+x+1), advancing one step every cycle.
REQ-016 A RANDOM write SHALL load wdata as seed that cycle, overriding the step; a seed of 0 SHALL load 32'h0000_0001.
REQ-017 INT_CLEAR SHALL store the low INT_WIDTH bits of the last write; upper bits read 0.
REQ-018 An INT_CLEAR write SHALL clear INT_STATUS bits where wdata has 1, in the same cycle (write-1-to-clear action).
REQ-019 INT_STATUS bit i SHALL set on any cycle where int_src[i]=1 and remain set until cleared.
REQ-020 Simultaneous set and clear of the same status bit SHALL leave it set.
REQ-021 MASK SHALL store the low INT_WIDTH bits of wdata on write; 1 = enabled.
REQ-022 irq SHALL equal |(INT_STATUS & MASK) registered: asserts one cycle after the status/mask update that causes it.
REQ-023 On rd_strobe=1, rdata SHALL load the register selected by r_en_all the next edge; latency 1 cycle.
REQ-024 rdata SHALL load 0 when rd_strobe=1 and r_en_all is zero or not one-hot.
REQ-025 rdata SHALL hold its value when rd_strobe=0.
REQ-026 RANDOM read SHALL return the LFSR value before that cycle's step; read and write in one cycle SHALL be unsupported by the upstream (wr_strobe/rd_strobe mutually exclusive).
REQ-027 TYPE and INT_STATUS SHALL be unaffected by any write.

Reset
REQ-028 rst=1 SHALL asynchronously set: LFSR=32'h0000_0001, INT_CLEAR=0, INT_STATUS=0, MASK=0, rdata=0, irq=0.
REQ-029 Reset mid-transfer SHALL discard the transfer; first edge after release resumes normal operation with LFSR stepping.

Structure
REQ-030 Shared package apb_csr_pkg SHALL hold register offsets (8'h00..8'h04), w_en/r_en bit indices, LFSR taps, LFSR reset value.
REQ-031 The LFSR SHALL be a sub-module apb_csr_lfsr (ports clk, rst, load, seed, value).

Verification
REQ-032 Reset then read TYPE -> rdata=32'h0000_A5C1 one cycle after rd_strobe; irq=0.
REQ-033 Write RANDOM=32'h0000_0000, next cycle read -> rdata=32'h0000_0001; following read step matches reference LFSR model.
REQ-034 Pulse int_src=8'h05 one cycle, MASK=8'h04 -> INT_STATUS=8'h05, irq=1 one cycle after MASK write.
REQ-035 Write INT_CLEAR=8'h04 while int_src[2]=1 -> bit 2 stays set; repeat with int_src=0 -> INT_STATUS=8'h01, irq falls next cycle.
REQ-036 rd_strobe with r_en_all=5'b00011 -> rdata=0; wr_strobe=0 with w_en_all=3'b100 -> MASK unchanged.
REQ-037 Assert rst between wr_strobe and read-back of MASK=8'hFF -> MASK reads 0, irq=0.

Source files
------------

// File: rtl/apb_csr_pkg.sv
// Shared constants for the APB CSR block: register offsets, decoder select
// bit positions and the RANDOM LFSR polynomial.
package apb_csr_pkg;

  localparam logic [7:0] OFF_TYPE       = 8'h00;
  localparam logic [7:0] OFF_RANDOM     = 8'h01;
  localparam logic [7:0] OFF_INT_CLEAR  = 8'h02;
  localparam logic [7:0] OFF_INT_STATUS = 8'h03;
  localparam logic [7:0] OFF_MASK       = 8'h04;

  // w_en_all = {MASK, INT_CLEAR, RANDOM}
  localparam int W_RANDOM    = 0;
  localparam int W_INT_CLEAR = 1;
  localparam int W_MASK      = 2;

  // r_en_all = {MASK, INT_STATUS, INT_CLEAR, RANDOM, TYPE}
  localparam int R_TYPE       = 0;
  localparam int R_RANDOM     = 1;
  localparam int R_INT_CLEAR  = 2;
  localparam int R_INT_STATUS = 3;
  localparam int R_MASK       = 4;

  localparam int          LFSR_WIDTH = 32;
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

  // One right-shifting Galois step; the shifted-out bit folds back through the taps.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/apb_csr_lfsr.sv
// Free-running 32-bit Galois LFSR with a seed load that overrides the step.
module apb_csr_lfsr
  import apb_csr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [LFSR_WIDTH-1:0] seed,
  output logic [LFSR_WIDTH-1:0] value
);

  logic [LFSR_WIDTH-1:0] value_q;
  logic [LFSR_WIDTH-1:0] value_d;

  always_comb begin
    value_d = lfsr_step(value_q);
    if (load) begin
      // an all-zero state would lock the register up
      value_d = (seed == '0) ? LFSR_RESET : seed;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= LFSR_RESET;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/apb_csr_regs.sv
// APB CSR register file: TYPE, RANDOM (LFSR), INT_CLEAR, INT_STATUS, MASK,
// with registered read data and a registered masked interrupt.
module apb_csr_regs
  import apb_csr_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          INT_WIDTH  = 8,
  parameter logic [31:0] TYPE_VALUE = 32'h0000_A5C1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_strobe,
  input  logic                  rd_strobe,
  input  logic [2:0]            w_en_all,
  input  logic [4:0]            r_en_all,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [INT_WIDTH-1:0]  int_src,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  irq
);

  logic [INT_WIDTH-1:0]  clr_q, clr_d;
  logic [INT_WIDTH-1:0]  status_q, status_d;
  logic [INT_WIDTH-1:0]  mask_q, mask_d;
  logic [INT_WIDTH-1:0]  clr_hit;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  irq_q, irq_d;
  logic                  lfsr_load;
  logic [LFSR_WIDTH-1:0] lfsr_value;

  assign lfsr_load = wr_strobe & w_en_all[W_RANDOM];

  apb_csr_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .seed  (wdata[LFSR_WIDTH-1:0]),
    .value (lfsr_value)
  );

  assign clr_hit = (wr_strobe & w_en_all[W_INT_CLEAR]) ? wdata[INT_WIDTH-1:0] : '0;

  // a new request wins over a clear landing on the same bit
  for (genvar gi = 0; gi < INT_WIDTH; gi++) begin : g_status
    assign status_d[gi] = int_src[gi] | (status_q[gi] & ~clr_hit[gi]);
  end

  always_comb begin
    clr_d  = clr_q;
    mask_d = mask_q;
    if (wr_strobe) begin
      if (w_en_all[W_INT_CLEAR]) clr_d  = wdata[INT_WIDTH-1:0];
      if (w_en_all[W_MASK])      mask_d = wdata[INT_WIDTH-1:0];
    end
  end

  assign irq_d = |(status_q & mask_q);

  always_comb begin
    rdata_d = rdata_q;
    if (rd_strobe) begin
      case (r_en_all)
        5'(1 << R_TYPE):       rdata_d = DATA_WIDTH'(TYPE_VALUE);
        5'(1 << R_RANDOM):     rdata_d = DATA_WIDTH'(lfsr_value);
        5'(1 << R_INT_CLEAR):  rdata_d = DATA_WIDTH'(clr_q);
        5'(1 << R_INT_STATUS): rdata_d = DATA_WIDTH'(status_q);
        5'(1 << R_MASK):       rdata_d = DATA_WIDTH'(mask_q);
        default:               rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_q    <= '0;
      status_q <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      clr_q    <= clr_d;
      status_q <= status_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule
